// File: rtl/pearson_hash_pkg.sv
// Shared register map, widths and Pearson permutation for the AXI4-Lite hash block.
package pearson_hash_pkg;

  localparam int DATA_W = 32;
  localparam int HASH_W = 8;
  localparam int CNT_W  = 16;

  localparam logic [3:0] OFF_CTRL   = 4'h0;
  localparam logic [3:0] OFF_DATA   = 4'h4;
  localparam logic [3:0] OFF_STATUS = 4'h8;
  localparam logic [3:0] OFF_HASH   = 4'hC;

  typedef enum logic [1:0] {
    REG_CTRL   = OFF_CTRL[3:2],
    REG_DATA   = OFF_DATA[3:2],
    REG_STATUS = OFF_STATUS[3:2],
    REG_HASH   = OFF_HASH[3:2]
  } reg_idx_e;

  // T[i] = (167*i + 13) mod 256; 167 is odd, so this is a bijection on 8 bits.
  function automatic logic [HASH_W-1:0] pearson_t(input logic [HASH_W-1:0] i);
    return 8'd167 * i + 8'd13;
  endfunction

endpackage

// File: rtl/pearson_hash_core.sv
// Byte-serial Pearson hash engine: folds one byte of a 32-bit word per cycle.
module pearson_hash_core
  import pearson_hash_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic              start,
  input  logic [DATA_W-1:0] word,
  output logic [HASH_W-1:0] hash,
  output logic [CNT_W-1:0]  byte_cnt,
  output logic              busy,
  output logic              busy_nxt
);

  logic [DATA_W-1:0] word_q;
  logic [1:0]        idx;
  logic [7:0]        cur_byte;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cur_byte = word_q[7:0];
    case (idx)
      2'd1:    cur_byte = word_q[15:8];
      2'd2:    cur_byte = word_q[23:16];
      2'd3:    cur_byte = word_q[31:24];
      default: cur_byte = word_q[7:0];
    endcase
  end

  // Exposed so the bus side can open the write gate in the very cycle BUSY drops.
  always_comb begin
    busy_nxt = busy && (idx != 2'd3);
    if (start) busy_nxt = 1'b1;
    if (init)  busy_nxt = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      hash     <= '0;
      byte_cnt <= '0;
      busy     <= 1'b0;
      idx      <= '0;
      word_q   <= '0;
    end else begin
      busy <= busy_nxt;
      if (init) begin
        hash     <= '0;
        byte_cnt <= '0;
        idx      <= '0;
      end else if (start) begin
        word_q <= word;
        idx    <= '0;
      end else if (busy) begin
        hash     <= pearson_t(hash ^ cur_byte);
        byte_cnt <= byte_cnt + 1'b1;
        idx      <= idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pearson_hash_axil_slave.sv
// AXI4-Lite slave wrapping the Pearson hash core: CTRL/DATA/STATUS/HASH registers.
module pearson_hash_axil_slave
  import pearson_hash_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);

  reg_idx_e          wr_idx, rd_idx;
  logic [DATA_W-1:0] data_q, rd_mux;
  logic [HASH_W-1:0] hash;
  logic [CNT_W-1:0]  byte_cnt;
  logic              busy, busy_nxt;
  logic              wr_fire, rd_fire, can_wr, core_start, core_init;
  logic              unused_bits;

  assign wr_idx  = reg_idx_e'(S_AXI_AWADDR[3:2]);
  assign rd_idx  = reg_idx_e'(S_AXI_ARADDR[3:2]);
  assign wr_fire = S_AXI_AWREADY && S_AXI_AWVALID && S_AXI_WVALID;
  assign rd_fire = S_AXI_ARREADY && S_AXI_ARVALID;

  // Ready is registered, so gate on the state the acceptance cycle will see.
  assign can_wr = S_AXI_AWVALID && S_AXI_WVALID && !S_AXI_AWREADY
               && !(S_AXI_BVALID && !S_AXI_BREADY)
               && !(wr_idx == REG_DATA && busy_nxt);

  assign core_start = wr_fire && (wr_idx == REG_DATA);
  assign core_init  = wr_fire && (wr_idx == REG_CTRL) && S_AXI_WSTRB[0] && S_AXI_WDATA[0];

  assign S_AXI_BRESP = 2'b00;
  assign S_AXI_RRESP = 2'b00;
  assign unused_bits = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                         S_AXI_WSTRB[C_S_AXI_DATA_WIDTH/8-1:1]};

  always_comb begin
    rd_mux = '0;
    unique case (rd_idx)
      REG_CTRL:   rd_mux = '0;
      REG_DATA:   rd_mux = data_q;
      REG_STATUS: rd_mux = {byte_cnt, {(DATA_W-CNT_W-1){1'b0}}, busy};
      REG_HASH:   rd_mux = {{(DATA_W-HASH_W){1'b0}}, hash};
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
      data_q        <= '0;
    end else begin
      S_AXI_AWREADY <= can_wr;
      S_AXI_WREADY  <= can_wr;
      if (wr_fire) begin
        S_AXI_BVALID <= 1'b1;
        if (wr_idx == REG_DATA) data_q <= S_AXI_WDATA;
      end else if (S_AXI_BVALID && S_AXI_BREADY) begin
        S_AXI_BVALID <= 1'b0;
      end

      S_AXI_ARREADY <= S_AXI_ARVALID && !S_AXI_RVALID && !S_AXI_ARREADY;
      if (rd_fire) begin
        S_AXI_RVALID <= 1'b1;
        S_AXI_RDATA  <= rd_mux;
      end else if (S_AXI_RVALID && S_AXI_RREADY) begin
        S_AXI_RVALID <= 1'b0;
      end
    end
  end

  pearson_hash_core u_core (
    .clk      (S_AXI_ACLK),
    .rst      (S_AXI_ARESET),
    .init     (core_init),
    .start    (core_start),
    .word     (S_AXI_WDATA),
    .hash     (hash),
    .byte_cnt (byte_cnt),
    .busy     (busy),
    .busy_nxt (busy_nxt)
  );

endmodule

// File: tb/tb_pearson_hash_axil_slave.sv
// Self-checking bench for pearson_hash_axil_slave against a word-level reference model.
module tb_pearson_hash_axil_slave;

  localparam logic [3:0] A_CTRL   = 4'h0;
  localparam logic [3:0] A_DATA   = 4'h4;
  localparam logic [3:0] A_STATUS = 4'h8;
  localparam logic [3:0] A_HASH   = 4'hC;
  localparam int         LIMIT    = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  awaddr, araddr, wstrb;
  logic [31:0] wdata, rdata;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [7:0]  m_h;
  logic [15:0] m_cnt;
  logic [31:0] m_data;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pearson_hash_axil_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESET  (rst),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: T[i] = (167*i + 13) mod 256 with plain integer arithmetic.
  function automatic logic [7:0] t_ref(input int i);
    return 8'((167 * i + 13) % 256);
  endfunction

  task automatic model_data(input logic [31:0] w);
    m_data = w;
    for (int b = 0; b < 4; b++) begin
      m_h   = t_ref(int'(m_h ^ w[8*b +: 8]));
      m_cnt = m_cnt + 16'd1;
    end
  endtask

  task automatic model_init();
    m_h   = 8'd0;
    m_cnt = 16'd0;
  endtask

  function automatic logic [31:0] status_exp();
    return {m_cnt, 16'd0};
  endfunction

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           output int acc_cyc);
    int n;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    while (!(awready && wready) && n < LIMIT) begin @(negedge clk); n++; end
    check("wr_accept_timeout", 32'(n >= LIMIT), 32'd0);
    acc_cyc = cyc;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < LIMIT) begin @(negedge clk); n++; end
    check("bresp_okay", {30'd0, bresp}, 32'd0);
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
    int n;
    @(negedge clk);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    while (!arready && n < LIMIT) begin @(negedge clk); n++; end
    @(negedge clk);
    arvalid = 1'b0;
    while (!rvalid && n < LIMIT) begin @(negedge clk); n++; end
    if (n >= LIMIT) check("rd_timeout", 32'(n), 32'd0);
    d = rdata;
  endtask

  task automatic poll_idle();
    logic [31:0] st;
    int tries = 0;
    st = 32'd1;
    while (st[0] && tries < 20) begin axi_read(A_STATUS, st); tries++; end
    check("busy_clear_timeout", {31'd0, st[0]}, 32'd0);
  endtask

  initial begin
    logic [31:0] d, w, w2, old;
    logic [3:0]  s;
    int c1, c2, n;
    logic spurious;

    rst = 1'b1;
    awaddr = '0; wdata = '0; wstrb = '0; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    araddr = '0; arvalid = 1'b0; rready = 1'b1;
    m_h = 8'd0; m_cnt = 16'd0; m_data = 32'd0;
    repeat (3) @(negedge clk);

    check("rst_handshakes", {25'd0, awready, wready, bvalid, arready, rvalid, bresp != 2'b00},
          32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_rresp", {30'd0, rresp}, 32'd0);
    rst = 1'b0;
    axi_read(A_STATUS, d); check("rst_status", d, 32'd0);
    axi_read(A_HASH, d);   check("rst_hash", d, 32'd0);
    axi_read(A_DATA, d);   check("rst_data", d, 32'd0);

    // Known vector: INIT then DATA=1.
    axi_write(A_CTRL, 32'd1, 4'hF, c1); model_init();
    axi_write(A_DATA, 32'd1, 4'hF, c1); model_data(32'd1);
    poll_idle();
    axi_read(A_HASH, d);   check("vec_hash", d, 32'h0000_0071); check("vec_hash_model", d, {24'd0, m_h});
    axi_read(A_STATUS, d); check("vec_status", d, 32'h0004_0000);
    axi_read(A_CTRL, d);   check("ctrl_reads_zero", d, 32'd0);
    axi_read(A_DATA, d);   check("data_readback", d, 32'd1);

    // Back-to-back DATA writes: second stalls until the four bytes are done.
    axi_write(A_CTRL, 32'd1, 4'h1, c1); model_init();
    w = $urandom; w2 = $urandom;
    axi_write(A_DATA, w, 4'hF, c1);  model_data(w);
    axi_write(A_DATA, w2, 4'h0, c2); model_data(w2);
    check("stall_gap", 32'(c2 - c1), 32'd5);
    poll_idle();
    axi_read(A_STATUS, d); check("b2b_status", d, 32'h0008_0000);
    axi_read(A_HASH, d);   check("b2b_hash", d, {24'd0, m_h});

    // Random words with random (ignored) strobes.
    for (int i = 0; i < 6; i++) begin
      w = $urandom; s = 4'($urandom_range(0, 15));
      axi_write(A_DATA, w, s, c1); model_data(w);
      poll_idle();
      axi_read(A_HASH, d);   check("rand_hash", d, {24'd0, m_h});
      axi_read(A_STATUS, d); check("rand_status", d, status_exp());
      axi_read(A_DATA, d);   check("rand_data", d, m_data);
    end

    // BREADY held low: BVALID stays, a queued write is not accepted.
    @(negedge clk);
    awaddr = A_HASH; wdata = 32'h1234_5678; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    n = 0;
    while (!awready && n < LIMIT) begin @(negedge clk); n++; end
    @(negedge clk);
    awaddr = A_CTRL; wdata = 32'd0;
    for (int i = 0; i < 10; i++) begin
      check("bvalid_held", {31'd0, bvalid}, 32'd1);
      check("no_accept_while_bvalid", {30'd0, awready, wready}, 32'd0);
      @(negedge clk);
    end
    bready = 1'b1;
    n = 0;
    while (!awready && n < LIMIT) begin @(negedge clk); n++; end
    check("queued_write_timeout", 32'(n >= LIMIT), 32'd0);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < LIMIT) begin @(negedge clk); n++; end
    check("queued_bresp", {30'd0, bresp}, 32'd0);

    // RREADY held low: RDATA stable even while DATA is rewritten.
    old = m_data;
    @(negedge clk);
    araddr = A_DATA; arvalid = 1'b1; rready = 1'b0;
    n = 0;
    while (!arready && n < LIMIT) begin @(negedge clk); n++; end
    @(negedge clk);
    arvalid = 1'b0;
    w = $urandom;
    axi_write(A_DATA, w, 4'hF, c1); model_data(w);
    repeat (3) @(negedge clk);
    check("rvalid_held", {31'd0, rvalid}, 32'd1);
    check("rdata_stable", rdata, old);
    rready = 1'b1;
    poll_idle();

    // INIT during BUSY aborts the engine.
    w = $urandom;
    axi_write(A_DATA, w, 4'hF, c1); model_data(w);
    axi_write(A_CTRL, 32'd1, 4'h1, c2); model_init();
    check("init_accepted_while_busy", 32'((c2 - c1) <= 4), 32'd1);
    axi_read(A_HASH, d);   check("init_hash", d, 32'd0);
    axi_read(A_STATUS, d); check("init_status", d, 32'd0);
    repeat (6) @(negedge clk);
    axi_read(A_STATUS, d); check("init_no_more_bytes", d, 32'd0);
    axi_read(A_DATA, d);   check("init_data_kept", d, m_data);

    // Writes to read-only registers and INIT with WSTRB[0]=0 are ignored.
    w = $urandom;
    axi_write(A_DATA, w, 4'hF, c1); model_data(w);
    poll_idle();
    axi_write(A_HASH, 32'hDEAD_BEEF, 4'hF, c1);
    axi_write(A_STATUS, 32'hDEAD_BEEF, 4'hF, c1);
    axi_write(A_CTRL, 32'd1, 4'b1110, c1);
    axi_read(A_HASH, d);   check("ro_hash", d, {24'd0, m_h});
    axi_read(A_STATUS, d); check("ro_status", d, status_exp());

    // Read and DATA write accepted in the same cycle: read sees the old word.
    old = m_data; w = ~m_data;
    @(negedge clk);
    awaddr = A_DATA; wdata = w; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    araddr = A_DATA; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    while (!awready && n < LIMIT) begin @(negedge clk); n++; end
    check("ar_aw_same_cycle", {31'd0, arready}, 32'd1);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < LIMIT) begin @(negedge clk); n++; end
    check("read_pre_write", rdata, old);
    model_data(w);
    poll_idle();
    axi_read(A_DATA, d); check("post_write_data", d, w);

    // Reset in the middle of a hash with BVALID pending.
    axi_read(A_DATA, d);
    @(negedge clk);
    awaddr = A_DATA; wdata = $urandom; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    n = 0;
    while (!awready && n < LIMIT) begin @(negedge clk); n++; end
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    check("pre_rst_bvalid", {31'd0, bvalid}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_handshakes", {25'd0, awready, wready, bvalid, arready, rvalid, bresp != 2'b00},
          32'd0);
    check("mid_rst_rdata", rdata, 32'd0);
    rst = 1'b0; bready = 1'b1;
    m_h = 8'd0; m_cnt = 16'd0; m_data = 32'd0;
    spurious = 1'b0;
    repeat (8) begin @(negedge clk); if (bvalid || rvalid) spurious = 1'b1; end
    check("no_resp_after_rst", {31'd0, spurious}, 32'd0);
    axi_read(A_HASH, d);   check("post_rst_hash", d, 32'd0);
    axi_read(A_STATUS, d); check("post_rst_status", d, status_exp());
    axi_read(A_DATA, d);   check("post_rst_data", d, m_data);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pearson_hash_axil_slave.md
PEARSON_HASH_AXIL_SLAVE -- requirements
Module: pearson_hash_axil_slave

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4, byte address width; index = ADDR[3:2].
REQ-003 SHALL have S_AXI_ACLK  in  1  single clock; all logic rising-edge.
REQ-004 SHALL have S_AXI_ARESET  in  1  reset, synchronous, active-high.
REQ-005 SHALL have S_AXI_AWADDR  in  4  write address.
REQ-006 SHALL have S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake.
REQ-007 SHALL have S_AXI_WDATA  in  32  write data.
REQ-008 SHALL have S_AXI_WSTRB  in  4  write byte strobes.
REQ-009 SHALL have S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake.
REQ-010 SHALL have S_AXI_BRESP  out  2  always 2'b00 (OKAY).
REQ-011 SHALL have S_AXI_BVALID / S_AXI_BREADY  out / in  1  write-response handshake.
REQ-012 SHALL have S_AXI_ARADDR  in  4  read address.
REQ-013 SHALL have S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake.
REQ-014 SHALL have S_AXI_RDATA  out  32  read data.
REQ-015 SHALL have S_AXI_RRESP  out  2  always 2'b00.
REQ-016 SHALL have S_AXI_RVALID / S_AXI_RREADY  out / in  1  read-data handshake.

Function
REQ-017 SHALL map registers: 0x0 CTRL (W: bit0 INIT, reads 0); 0x4 DATA (W, reads last written word); 0x8 STATUS (RO: bit0 BUSY, [31:16] BYTE_CNT); 0xC HASH (RO: [7:0] hash, upper bits 0).
REQ-018 SHALL accept a write only when AWVALID and WVALID are both high, BVALID is low, and (target is not DATA or BUSY=0); AWREADY and WREADY then pulse high together for exactly one cycle.
REQ-019 SHALL assert BVALID the cycle after write acceptance and hold it until BREADY sampled high.
REQ-020 SHALL, on ARVALID with RVALID low, pulse ARREADY one cycle, latch RDATA, assert RVALID next cycle, hold RDATA/RVALID until RREADY.
REQ-021 SHALL process reads and writes independently; a read in the DATA-accept cycle returns pre-write register values.
REQ-022 SHALL ignore writes to STATUS/HASH (still OKAY); CTRL INIT honoured only if WSTRB[0]=1; DATA ignores WSTRB, always hashes 4 bytes.
REQ-023 SHALL, on DATA accept at cycle N, hash bytes WDATA[7:0],[15:8],[23:16],[31:24] one per cycle in cycles N+1..N+4, BUSY=1 in N+1..N+4, BUSY=0 from N+5.
REQ-024 SHALL compute per byte h <= T[h XOR byte], T[i] = (167*i + 13) mod 256 (8-bit permutation).
REQ-025 SHALL increment BYTE_CNT by one per hashed byte, 16-bit wrap 0xFFFF -> 0x0000.
REQ-026 SHALL accept INIT writes while BUSY; INIT aborts engine, sets h=0, BYTE_CNT=0, BUSY=0 next cycle.
REQ-027 SHALL hold AWREADY/WREADY low for DATA writes while BUSY (stall, no drop).

Reset
REQ-028 SHALL, with S_AXI_ARESET high at a clock edge, clear all outputs (READYs, BVALID, RVALID, RDATA, BRESP, RRESP) to 0, h=0, BYTE_CNT=0, BUSY=0, DATA=0.
REQ-029 SHALL discard any in-flight transaction or hash on reset mid-operation; no response issued afterwards.

Structure
REQ-030 SHALL place register offsets, width constants and the T function/table in shared package pearson_hash_pkg.
REQ-031 SHALL isolate the byte-serial hash datapath (h, byte counter, busy, 2-bit byte index) in sub-module pearson_hash_core.

Verification
REQ-032 SHALL cover: INIT, write DATA=0x00000001, poll STATUS until BUSY=0 -> HASH reads 0x00000071, STATUS reads 0x00040000.
REQ-033 SHALL cover: write DATA then immediate second DATA write -> second AWREADY/WREADY held low until BUSY=0, BYTE_CNT ends 0x0008.
REQ-034 SHALL cover: BREADY held low 10 cycles -> BVALID held, no further write accepted; RREADY low -> RDATA stable.
REQ-035 SHALL cover: INIT written during BUSY -> HASH=0x00, BYTE_CNT=0 next read, no further bytes hashed.
REQ-036 SHALL cover: reset asserted mid-hash and mid-BVALID -> all outputs 0 cycle after, HASH reads 0 after release.
REQ-037 SHALL cover: write 0xDEADBEEF to HASH and STATUS -> BRESP OKAY, values unchanged.
